// File: rtl/fpu_inflight_scoreboard_pkg.sv
// Shared constants and slot record for the FP in-flight scoreboard.
// The slot record's countdown width follows FpuMaxLatency.
package fpu_inflight_scoreboard_pkg;

  localparam int unsigned FpuInflightSlots = 6;
  localparam int unsigned FpuMaxLatency    = 7;
  localparam int unsigned FpuLatW          = $clog2(FpuMaxLatency + 1);
  localparam int unsigned FpRegW           = 5;

  typedef struct packed {
    logic              valid;
    logic [FpRegW-1:0] dest;
    logic [FpuLatW-1:0] cnt;
  } fpu_inflight_slot_t;

endpackage

// File: rtl/fpu_inflight_slot.sv
// One tracked in-flight FP op: load on issue, count down while not stalled,
// clear on retire or flush.
module fpu_inflight_slot
  import fpu_inflight_scoreboard_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_load,
  input  logic [FpRegW-1:0]  i_load_dest,
  input  logic [FpuLatW-1:0] i_load_cnt,
  output fpu_inflight_slot_t o_slot,
  output logic               o_retire
);

  fpu_inflight_slot_t slot_q, slot_d;

  assign o_retire = slot_q.valid && (slot_q.cnt == FpuLatW'(1)) && !i_stall;
  assign o_slot   = slot_q;

  // Load wins over retire so a retiring slot can be reused on the same edge.
  always_comb begin
    slot_d = slot_q;
    if (i_flush) begin
      slot_d = '0;
    end else if (i_load) begin
      slot_d.valid = 1'b1;
      slot_d.dest  = i_load_dest;
      slot_d.cnt   = i_load_cnt;
    end else if (o_retire) begin
      slot_d = '0;
    end else if (slot_q.valid && !i_stall && (slot_q.cnt > FpuLatW'(1))) begin
      slot_d.cnt = slot_q.cnt - FpuLatW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/fpu_inflight_scoreboard.sv
// Tracks pipelined FP ops from EX issue to writeback, exposing per-slot
// destinations for hazard detection and arbitrating the single FP write port.
module fpu_inflight_scoreboard
  import fpu_inflight_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = FpuInflightSlots,
  parameter int unsigned MAX_LATENCY = FpuMaxLatency,
  localparam int unsigned LAT_W      = $clog2(MAX_LATENCY + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_issue_valid,
  input  logic [4:0]             i_issue_dest,
  input  logic [LAT_W-1:0]       i_issue_latency,
  output logic                   o_issue_ready,
  output logic [NUM_SLOTS-1:0]   o_inflight_valid,
  output logic [NUM_SLOTS*5-1:0] o_inflight_dest,
  output logic                   o_retire_valid,
  output logic [4:0]             o_retire_dest,
  output logic                   o_busy
);

  fpu_inflight_slot_t   slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] retire_vec;
  logic [NUM_SLOTS-1:0] free_vec;
  logic [NUM_SLOTS-1:0] collide_vec;
  logic [NUM_SLOTS-1:0] load_vec;
  logic [FpuLatW-1:0]   lat;
  logic [FpuLatW:0]     lat_plus1;
  logic                 lat_ok;
  logic                 accept;

  assign lat       = FpuLatW'(i_issue_latency);
  assign lat_plus1 = {1'b0, lat} + (FpuLatW + 1)'(1);
  assign lat_ok    = (i_issue_latency != '0) && (32'(i_issue_latency) <= MAX_LATENCY);

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    fpu_inflight_slot u_slot (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_stall     (i_stall),
      .i_flush     (i_flush),
      .i_load      (load_vec[k]),
      .i_load_dest (i_issue_dest),
      .i_load_cnt  (lat),
      .o_slot      (slots[k]),
      .o_retire    (retire_vec[k])
    );

    assign free_vec[k]    = !slots[k].valid || retire_vec[k];
    // A live slot with cnt == L+1 would retire in the same cycle as the new op.
    assign collide_vec[k] = slots[k].valid && ({1'b0, slots[k].cnt} == lat_plus1);

    assign o_inflight_valid[k]       = slots[k].valid;
    assign o_inflight_dest[5*k +: 5] = slots[k].dest;
  end

  assign o_issue_ready = (|free_vec) && !(|collide_vec);
  assign accept = i_issue_valid && !i_stall && !i_flush && o_issue_ready && lat_ok;

  always_comb begin
    logic found;
    found    = 1'b0;
    load_vec = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (accept && free_vec[k] && !found) begin
        load_vec[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // At most one slot retires per cycle, so an AND-OR select suffices.
  always_comb begin
    o_retire_dest = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      o_retire_dest = o_retire_dest | (slots[k].dest & {5{retire_vec[k]}});
    end
  end

  assign o_retire_valid = |retire_vec;
  assign o_busy         = |o_inflight_valid;

  issue_legal_a: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_issue_valid && !i_stall && !i_flush) |-> (lat_ok && o_issue_ready));

  single_retire_a: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(retire_vec));

endmodule
